mmu_task_loader: RTL and testbench

//  Bus-initiator counterpart of the MMU/DAT register responder. On request it

---
 rtl/mmu_task_loader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mmu_task_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_task_loader.sv
// Bus initiator that saves the active MMU task, programs one DAT task's page
// entries (optionally verifying them), then restores/activates a task.
module mmu_task_loader #(
  parameter int NUM_PAGES   = 8,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic        e,
  input  logic        _reset,
  input  logic        start,
  input  logic [11:0] task_num,
  input  logic [7:0]  base_bank,
  input  logic [7:0]  attr,
  input  logic        ext_mode,
  input  logic        verify,
  input  logic        activate,
  input  logic        enable_mmu,
  input  logic        crm_on,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] address_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        r_w_out,
  input  logic [7:0]  data_in
);

  localparam int IW = $clog2(2 * NUM_PAGES);
  localparam int TW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_SAV_LO, S_SAV_HI, S_SEL_LO, S_SEL_HI,
    S_WR, S_RD, S_RST_LO, S_RST_HI, S_ENA, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          active_q, active_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          bus_req_q, bus_req_d, data_oe_q, data_oe_d, r_w_q, r_w_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [11:0]   task_q, task_d;
  logic [7:0]    base_q, base_d, attr_q, attr_d;
  logic          ext_q, ext_d, verify_q, verify_d, act_q, act_d;
  logic          ena_q, ena_d, crm_q, crm_d;
  logic [4:0]    save_lo_q, save_lo_d;
  logic [6:0]    save_hi_q, save_hi_d;

  logic [IW-1:0] last_idx;
  logic [4:0]    rst_lo;
  logic [6:0]    rst_hi;

  // Ext mode interleaves attribute byte (even index) and bank (odd index).
  function automatic logic [7:0] entry_val(input logic [IW-1:0] i, input logic ext,
                                           input logic [7:0] base, input logic [7:0] at);
    if (ext) return i[0] ? base + 8'(i >> 1) : at;
    return base + 8'(i);
  endfunction

  assign last_idx = ext_q ? IW'(2 * NUM_PAGES - 1) : IW'(NUM_PAGES - 1);
  assign rst_lo   = act_q ? task_q[4:0]  : save_lo_q;
  assign rst_hi   = act_q ? task_q[11:5] : save_hi_q;

  // active_q means the bus op for (state_q, idx_q) is on the bus this cycle;
  // it completes at the next edge regardless of grant, then the next op waits for grant.
  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    error_d   = error_q;
    task_d    = task_q;
    base_d    = base_q;
    attr_d    = attr_q;
    ext_d     = ext_q;
    verify_d  = verify_q;
    act_d     = act_q;
    ena_d     = ena_q;
    crm_d     = crm_q;
    save_lo_d = save_lo_q;
    save_hi_d = save_hi_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          task_d   = task_num;
          base_d   = base_bank;
          attr_d   = attr;
          ext_d    = ext_mode;
          verify_d = verify;
          act_d    = activate;
          ena_d    = enable_mmu;
          crm_d    = crm_on;
          error_d  = 1'b0;
          tmo_d    = '0;
          idx_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_SAV_LO;
        end else if (tmo_q == TW'(GNT_TIMEOUT)) begin
          state_d = S_FIN;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (active_q) begin
          case (state_q)
            S_SAV_LO: begin
              save_lo_d = data_in[4:0];
              state_d   = S_SAV_HI;
            end
            S_SAV_HI: begin
              save_hi_d = data_in[6:0];
              state_d   = S_SEL_LO;
            end
            S_SEL_LO: state_d = S_SEL_HI;
            S_SEL_HI: begin
              idx_d   = '0;
              state_d = S_WR;
            end
            S_WR, S_RD: begin
              if (state_q == S_RD && data_in != entry_val(idx_q, ext_q, base_q, attr_q))
                error_d = 1'b1;
              if (idx_q == last_idx) begin
                idx_d   = '0;
                state_d = (state_q == S_WR && verify_q) ? S_RD : S_RST_LO;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            S_RST_LO: state_d = S_RST_HI;
            S_RST_HI: state_d = ena_q ? S_ENA : S_FIN;
            S_ENA:    state_d = S_FIN;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase

    busy_d    = !(state_d inside {S_IDLE, S_FIN});
    bus_req_d = busy_d;
    done_d    = (state_d == S_FIN);
  end

  // Bus op issue: registered outputs for the op the next cycle will carry.
  always_comb begin
    active_d  = 1'b0;
    addr_d    = 16'h0000;
    dout_d    = 8'h00;
    r_w_d     = 1'b1;
    data_oe_d = 1'b0;
    if (bus_gnt && state_d inside {S_SAV_LO, S_SAV_HI, S_SEL_LO, S_SEL_HI,
                                   S_WR, S_RD, S_RST_LO, S_RST_HI, S_ENA}) begin
      active_d  = 1'b1;
      r_w_d     = 1'b0;
      data_oe_d = 1'b1;
      case (state_d)
        S_SAV_LO: addr_d = 16'hFF91;
        S_SAV_HI: addr_d = 16'hFF97;
        S_SEL_LO: begin
          addr_d = 16'hFF91;
          dout_d = {1'b1, ext_q, 1'b0, task_q[4:0]};
        end
        S_SEL_HI: begin
          addr_d = 16'hFF97;
          dout_d = {1'b0, task_q[11:5]};
        end
        S_WR, S_RD: begin
          addr_d = 16'hFFA0 + 16'(idx_d);
          dout_d = (state_d == S_WR) ? entry_val(idx_d, ext_q, base_q, attr_q) : 8'h00;
        end
        S_RST_LO: begin
          addr_d = 16'hFF91;
          dout_d = {3'b000, rst_lo};
        end
        S_RST_HI: begin
          addr_d = 16'hFF97;
          dout_d = {1'b0, rst_hi};
        end
        S_ENA: begin
          addr_d = 16'hFF90;
          dout_d = {1'b0, 1'b1, 2'b00, crm_q, 3'b000};
        end
        default: addr_d = 16'h0000;
      endcase
      if (state_d inside {S_SAV_LO, S_SAV_HI, S_RD}) begin
        r_w_d     = 1'b1;
        data_oe_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge e) begin
    if (!_reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      bus_req_q <= 1'b0;
      data_oe_q <= 1'b0;
      r_w_q     <= 1'b1;
      addr_q    <= 16'h0000;
      dout_q    <= 8'h00;
      task_q    <= '0;
      base_q    <= '0;
      attr_q    <= '0;
      ext_q     <= 1'b0;
      verify_q  <= 1'b0;
      act_q     <= 1'b0;
      ena_q     <= 1'b0;
      crm_q     <= 1'b0;
      save_lo_q <= '0;
      save_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      bus_req_q <= bus_req_d;
      data_oe_q <= data_oe_d;
      r_w_q     <= r_w_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      task_q    <= task_d;
      base_q    <= base_d;
      attr_q    <= attr_d;
      ext_q     <= ext_d;
      verify_q  <= verify_d;
      act_q     <= act_d;
      ena_q     <= ena_d;
      crm_q     <= crm_d;
      save_lo_q <= save_lo_d;
      save_hi_q <= save_hi_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign bus_req     = bus_req_q;
  assign address_out = addr_q;
  assign data_out    = dout_q;
  assign data_oe     = data_oe_q;
  assign r_w_out     = r_w_q;

endmodule

// File: tb/tb_mmu_task_loader.sv
// Self-checking bench: MMU register-file responder, bus monitor and an
// op-list reference model derived from the loader's programming sequence.
module tb_mmu_task_loader;

  localparam int NP = 8;

  logic        e = 1'b0;
  logic        _reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] task_num = '0;
  logic [7:0]  base_bank = '0, attr = '0;
  logic        ext_mode = 1'b0, verify = 1'b0, activate = 1'b0;
  logic        enable_mmu = 1'b0, crm_on = 1'b0;
  logic        bus_gnt = 1'b0;
  logic [7:0]  data_in;
  logic        busy, done, error, bus_req, data_oe, r_w_out;
  logic [15:0] address_out;
  logic [7:0]  data_out;

  mmu_task_loader #(.NUM_PAGES(NP), .GNT_TIMEOUT(255)) dut (
    .e(e), ._reset(_reset), .start(start), .task_num(task_num),
    .base_bank(base_bank), .attr(attr), .ext_mode(ext_mode), .verify(verify),
    .activate(activate), .enable_mmu(enable_mmu), .crm_on(crm_on),
    .busy(busy), .done(done), .error(error), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .address_out(address_out), .data_out(data_out),
    .data_oe(data_oe), .r_w_out(r_w_out), .data_in(data_in)
  );

  always #5 e = ~e;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;

  int   checks = 0, errors = 0;
  op_t  obs_q[$], exp_q[$];
  logic [7:0]  regs [0:255];
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  int   gnt_mode = 0, drop_left = 0, wr_seen = 0, viol = 0, busy_cycles = 0;
  logic gnt_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always_comb begin
    data_in = 8'h00;
    if (address_out[15:8] == 8'hFF)
      data_in = regs[address_out[7:0]] ^ ((corrupt_en && address_out == corrupt_addr) ? 8'h5A : 8'h00);
  end

  always @(posedge e) gnt_prev <= bus_gnt;

  // Responder + monitor + grant driver, run mid-cycle.
  task automatic mon_step();
    if (_reset) begin
      if (address_out != 16'h0000) begin
        if (!gnt_prev) viol++;
        if (data_oe == r_w_out) viol++;
        obs_q.push_back('{rd: r_w_out, addr: address_out, data: r_w_out ? 8'h00 : data_out});
        if (!r_w_out) begin
          regs[address_out[7:0]] = data_out;
          if (address_out[7:4] == 4'hA) wr_seen++;
        end
      end else if (data_oe || !r_w_out) begin
        viol++;
      end
      if (busy) busy_cycles++;
    end
    case (gnt_mode)
      0: bus_gnt = 1'b1;
      1: bus_gnt = ($urandom_range(0, 3) != 0);
      2: bus_gnt = 1'b0;
      default: begin
        if (wr_seen >= 3 && drop_left > 0) begin
          bus_gnt = 1'b0;
          drop_left--;
        end else bus_gnt = 1'b1;
      end
    endcase
  endtask

  function automatic logic [7:0] exp_entry(input int i, input logic x, input logic [7:0] b, input logic [7:0] a);
    if (x) return (i % 2 == 0) ? a : 8'((int'(b) + i / 2) % 256);
    return 8'((int'(b) + i) % 256);
  endfunction

  task automatic run_txn(input string name, input logic [11:0] t, input logic [7:0] b,
                         input logic [7:0] a, input logic x, input logic v, input logic act,
                         input logic en, input logic crm, input int gmode,
                         input logic corr, input logic [15:0] caddr, input logic poke);
    int c, k, n;
    logic [7:0] i91, i97;
    logic exp_err, finished;
    logic [4:0] lo;
    logic [6:0] hi;
    @(negedge e); #1;
    i91 = 8'($urandom); i97 = 8'($urandom);
    regs[8'h91] = i91; regs[8'h97] = i97;
    exp_q.delete(); obs_q.delete();
    viol = 0; wr_seen = 0; busy_cycles = 0; drop_left = 3;
    gnt_mode = gmode; corrupt_en = corr; corrupt_addr = caddr;
    c = x ? 2 * NP : NP;
    if (gmode != 2) begin
      exp_q.push_back('{1'b1, 16'hFF91, 8'h00});
      exp_q.push_back('{1'b1, 16'hFF97, 8'h00});
      exp_q.push_back('{1'b0, 16'hFF91, {1'b1, x, 1'b0, t[4:0]}});
      exp_q.push_back('{1'b0, 16'hFF97, {1'b0, t[11:5]}});
      for (int i = 0; i < c; i++) exp_q.push_back('{1'b0, 16'hFFA0 + 16'(i), exp_entry(i, x, b, a)});
      if (v) for (int i = 0; i < c; i++) exp_q.push_back('{1'b1, 16'hFFA0 + 16'(i), 8'h00});
      lo = act ? t[4:0] : i91[4:0];
      hi = act ? t[11:5] : i97[6:0];
      exp_q.push_back('{1'b0, 16'hFF91, {3'b000, lo}});
      exp_q.push_back('{1'b0, 16'hFF97, {1'b0, hi}});
      if (en) exp_q.push_back('{1'b0, 16'hFF90, {1'b0, 1'b1, 2'b00, crm, 3'b000}});
    end
    exp_err = (gmode == 2) ||
              (v && corr && caddr >= 16'hFFA0 && caddr < 16'hFFA0 + 16'(c));
    task_num = t; base_bank = b; attr = a; ext_mode = x; verify = v;
    activate = act; enable_mmu = en; crm_on = crm; start = 1'b1;
    @(negedge e); #1;
    start = 1'b0;
    check({name, ".busy_start"}, 32'(busy), 32'd1);
    check({name, ".err_clr"}, 32'(error), 32'd0);
    // Inputs are latched at start; scrambling them must not affect the sequence.
    task_num = 12'($urandom); base_bank = 8'($urandom); attr = 8'($urandom);
    ext_mode = 1'($urandom); verify = 1'($urandom); activate = 1'($urandom);
    enable_mmu = 1'($urandom); crm_on = 1'($urandom);
    finished = 1'b0;
    for (k = 0; k < 3000; k++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      start = (poke && busy_cycles == 4);
      @(negedge e); #1;
    end
    start = 1'b0;
    check({name, ".done_seen"}, 32'(finished), 32'd1);
    check({name, ".error"}, 32'(error), 32'(exp_err));
    check({name, ".busy_fin"}, 32'(busy), 32'd0);
    check({name, ".bus_req_fin"}, 32'(bus_req), 32'd0);
    check({name, ".bus_viol"}, 32'(viol), 32'd0);
    check({name, ".n_ops"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.op%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
    if (gmode == 0) check({name, ".cycles"}, 32'(busy_cycles), 32'(exp_q.size() + 1));
    if (gmode == 2) check({name, ".req_cycles"}, 32'(busy_cycles), 32'd256);
    @(negedge e); #1;
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    corrupt_en = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge e);
        mon_step();
      end
    join_none

    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    repeat (3) @(negedge e);
    #1;
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.error", 32'(error), 0);
    check("rst.bus_req", 32'(bus_req), 0);
    check("rst.data_oe", 32'(data_oe), 0);
    check("rst.r_w", 32'(r_w_out), 1);
    check("rst.addr", 32'(address_out), 0);
    check("rst.dout", 32'(data_out), 0);
    _reset = 1'b1;

    run_txn("t1", 12'h005, 8'h38, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    run_txn("t2", 12'h005, 8'h10, 8'hC0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 2 * NP; i++)
      check($sformatf("t2.dat%0d", i), 32'(regs[8'hA0 + i]), 32'(exp_entry(i, 1'b1, 8'h10, 8'hC0)));
    run_txn("t3", 12'h123, 8'h40, 8'h00, 0, 1, 0, 0, 0, 0, 1, 16'hFFA3, 0);
    run_txn("t3b", 12'h123, 8'h40, 8'h00, 0, 1, 0, 0, 0, 0, 0, 16'h0, 0);
    run_txn("t4", 12'h7FF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2, 0, 16'h0, 0);
    run_txn("t5", 12'h010, 8'hFE, 8'h00, 0, 0, 0, 0, 0, 3, 0, 16'h0, 0);

    // Reset mid-write pass.
    @(negedge e); #1;
    gnt_mode = 0; wr_seen = 0;
    task_num = 12'h011; base_bank = 8'h20; ext_mode = 0; verify = 0; start = 1'b1;
    @(negedge e); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && wr_seen < 2; k++) begin
      @(negedge e); #1;
    end
    check("rstmid.in_wr", 32'(wr_seen >= 2 && busy), 1);
    _reset = 1'b0;
    @(negedge e); #1;
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.bus_req", 32'(bus_req), 0);
    check("rstmid.data_oe", 32'(data_oe), 0);
    check("rstmid.r_w", 32'(r_w_out), 1);
    check("rstmid.addr", 32'(address_out), 0);
    _reset = 1'b1;
    @(negedge e); #1;
    check("rstmid.idle", 32'(busy), 0);

    run_txn("t6", 12'h0A3, 8'h00, 8'h00, 0, 0, 1, 1, 1, 0, 0, 16'h0, 1);
    repeat (3) @(negedge e);
    #1;
    check("t6.no_restart", 32'(busy), 0);

    for (int r = 0; r < 20; r++)
      run_txn($sformatf("rnd%0d", r), 12'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1, 1'($urandom), 16'hFFA0 + 16'($urandom_range(0, 15)), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
